tl_cntr_timed: RTL and testbench

//   Timed two-road traffic light controller. The state register, next-state logic and

---
 rtl/tl_cntr_timed.sv | 88 ++++++++
 tb/tb_tl_cntr_timed.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/tl_cntr_timed.sv
// rtl/tl_cntr_timed.sv - timed two-road traffic light controller with dwell timer and hold
module tl_cntr_timed #(
    parameter int CNT_W     = 8,
    parameter int GREEN_MIN = 5,
    parameter int GREEN_MAX = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             Ta,
    input  logic             Tb,
    output logic [1:0]       La,
    output logic [1:0]       Lb,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] timer
);

    localparam logic [2:0] S_AG = 3'd0;
    localparam logic [2:0] S_AY = 3'd1;
    localparam logic [2:0] S_AR = 3'd2;
    localparam logic [2:0] S_BG = 3'd3;
    localparam logic [2:0] S_BY = 3'd4;
    localparam logic [2:0] S_BR = 3'd5;

    localparam logic [1:0] LAMP_G = 2'b00;
    localparam logic [1:0] LAMP_Y = 2'b01;
    localparam logic [1:0] LAMP_R = 2'b10;

    // Timer values at which each dwell rule fires (timer counts elapsed cycles minus one).
    localparam logic [CNT_W-1:0] T_GMIN = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] T_GMAX = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] T_YEL  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] T_AR   = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] T_SAT  = {CNT_W{1'b1}};

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_AG;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (!hold) begin
            case (state_q)
                S_AG: if ((timer_q >= T_GMIN && !Ta) || (timer_q >= T_GMAX && Tb)) state_d = S_AY;
                S_AY: if (timer_q == T_YEL) state_d = S_AR;
                S_AR: if (timer_q == T_AR)  state_d = S_BG;
                S_BG: if ((timer_q >= T_GMIN && !Tb) || (timer_q >= T_GMAX && Ta)) state_d = S_BY;
                S_BY: if (timer_q == T_YEL) state_d = S_BR;
                S_BR: if (timer_q == T_AR)  state_d = S_AG;
                default: state_d = S_AG;
            endcase
            // A phase change restarts the dwell count; otherwise count up and stick at the top.
            if (state_d != state_q) begin
                timer_d = '0;
            end else if (timer_q != T_SAT) begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    always_comb begin
        La = LAMP_R;
        Lb = LAMP_R;
        case (state_q)
            S_AG: La = LAMP_G;
            S_AY: La = LAMP_Y;
            S_BG: Lb = LAMP_G;
            S_BY: Lb = LAMP_Y;
            default: ;
        endcase
    end

    assign state = state_q;
    assign timer = timer_q;

endmodule

// File: tb/tb_tl_cntr_timed.sv
// tb/tb_tl_cntr_timed.sv - randomized self-checking bench for tl_cntr_timed
module tb_tl_cntr_timed;

    localparam int CNT_W = 8;
    localparam int GMIN  = 5;
    localparam int GMAX  = 20;
    localparam int YT    = 3;
    localparam int ART   = 1;
    localparam int TMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             hold;
    logic             Ta;
    logic             Tb;
    logic [1:0]       La;
    logic [1:0]       Lb;
    logic [2:0]       state;
    logic [CNT_W-1:0] timer;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase index 0..5 and elapsed-minus-one count.
    int ms;
    int mt;
    int la_tab [0:5] = '{2, 1, 2, 2, 2, 2};
    int lb_tab [0:5] = '{2, 2, 2, 0, 1, 2};

    tl_cntr_timed #(
        .CNT_W(CNT_W), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_T(YT), .ALLRED_T(ART)
    ) dut (
        .clk(clk), .reset(reset), .hold(hold), .Ta(Ta), .Tb(Tb),
        .La(La), .Lb(Lb), .state(state), .timer(timer)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit model_advance(input int s, input int t, input bit a, input bit b);
        case (s)
            0:       return (t >= GMIN - 1 && !a) || (t >= GMAX - 1 && b);
            3:       return (t >= GMIN - 1 && !b) || (t >= GMAX - 1 && a);
            1, 4:    return t == YT - 1;
            default: return t == ART - 1;
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        int exp_la;
        exp_la = (ms == 0) ? 0 : la_tab[ms];
        check_eq({tag, "_state"}, 32'(state), 32'(ms));
        check_eq({tag, "_timer"}, 32'(timer), 32'(mt));
        check_eq({tag, "_La"},    32'(La),    32'(exp_la));
        check_eq({tag, "_Lb"},    32'(Lb),    32'(lb_tab[ms]));
    endtask

    task automatic step(input bit a, input bit b, input bit h);
        Ta = a;
        Tb = b;
        hold = h;
        @(posedge clk);
        if (!h) begin
            if (model_advance(ms, mt, a, b)) begin
                ms = (ms + 1) % 6;
                mt = 0;
            end else if (mt < TMAX) begin
                mt = mt + 1;
            end
        end
        #1;
        check_outputs("step");
    endtask

    // Asynchronous reset applied between edges; outputs must settle before the next edge.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        ms = 0;
        mt = 0;
        #1;
        check_outputs("rst_async");
        @(posedge clk);
        #1;
        check_outputs("rst_held");
        reset = 1'b0;
    endtask

    // Number of cycles the current phase is displayed, including the current one.
    task automatic measure(input bit a, input bit b, output int len);
        int p;
        p = 32'(state);
        len = 1;
        for (int i = 0; i < 400; i++) begin
            step(a, b, 1'b0);
            if (32'(state) != p) return;
            len++;
        end
    endtask

    initial begin
        int len;
        int seq [0:5];
        if (!(GMIN >= 1 && GMAX > GMIN && YT >= 1 && ART >= 1 && GMAX < (1 << CNT_W))) begin
            $display("FAIL params: illegal parameter set");
            $fatal(1, "bad parameters");
        end
        reset = 1'b1;
        hold = 1'b0;
        Ta = 1'b0;
        Tb = 1'b0;
        ms = 0;
        mt = 0;
        #1;
        check_outputs("reset");
        @(posedge clk);
        #3;
        reset = 1'b0;

        // Free-running with empty roads: 5/3/1/5/3/1 dwells.
        seq = '{GMIN, YT, ART, GMIN, YT, ART};
        for (int k = 0; k < 12; k++) begin
            measure(1'b0, 1'b0, len);
            check_eq("idle_dwell", 32'(len), 32'(seq[k % 6]));
        end

        // Own road busy, cross empty: green forever, timer saturates.
        do_reset();
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 1'b0);
        check_eq("sat_state", 32'(state), 32'd0);
        check_eq("sat_timer", 32'(timer), 32'(TMAX));

        // Both roads busy: max green rule.
        do_reset();
        measure(1'b1, 1'b1, len);
        check_eq("both_ag", 32'(len), 32'(GMAX));
        measure(1'b1, 1'b1, len);
        check_eq("both_ay", 32'(len), 32'(YT));
        measure(1'b1, 1'b1, len);
        check_eq("both_ar", 32'(len), 32'(ART));
        measure(1'b1, 1'b1, len);
        check_eq("both_bg", 32'(len), 32'(GMAX));

        // Short sensor pulse still gets the full minimum green.
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        measure(1'b0, 1'b0, len);
        check_eq("min_green", 32'(len + 2), 32'(GMIN));

        // Hold at AY with t=1.
        do_reset();
        measure(1'b0, 1'b0, len);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b1, 1'b1);
            check_eq("hold_state", 32'(state), 32'd1);
            check_eq("hold_timer", 32'(timer), 32'd1);
        end
        measure(1'b0, 1'b0, len);
        check_eq("hold_resume", 32'(len), 32'(YT - 1));

        // Reset mid-BG.
        do_reset();
        for (int i = 0; i < 40 && state != 3'd3; i++) step(1'b0, 1'b0, 1'b0);
        check_eq("reach_bg", 32'(state), 32'd3);
        step(1'b1, 1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0),
                     1'($urandom_range(0, 7) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
